// File: rtl/proc_mem_pkg.sv
// proc_mem_pkg
// Shared constants and helpers for the shared-memory arbiter slice.
//   RD_FIRST / WR_FIRST : read-during-write selection for the RD_MODE parameter
//   idx_width()         : bits needed to hold a port index (never less than 1)
package proc_mem_pkg;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  // A single-port configuration still needs a 1-bit index so that the
  // pointer and grant-index signals never collapse to zero width.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/proc_mem_arb_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. The search for a requesting port
// starts at ptr and wraps around; the first requester found wins.
// Ports:
//   req       in  NPORTS  per-port request
//   ptr       in  IW      index of the highest-priority port this cycle
//   en        in  1       when low nothing is granted
//   grant     out NPORTS  one-hot grant (all zero when nothing granted)
//   grant_idx out IW      binary index of the granted port
//   any_grant out 1       a grant was issued this cycle
module rr_arbiter
  import proc_mem_pkg::*;
#(
  parameter int NPORTS = 2,
  localparam int IW = idx_width(NPORTS)
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IW-1:0]     ptr,
  input  logic              en,
  output logic [NPORTS-1:0] grant,
  output logic [IW-1:0]     grant_idx,
  output logic              any_grant
);

  logic [IW-1:0] cand;

  // Walk the ports in priority order ptr, ptr+1, ... and stop at the first
  // requester; any_grant doubles as the "already found" flag.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    if (en) begin
      for (int k = 0; k < NPORTS; k++) begin
        cand = IW'((int'(ptr) + k) % NPORTS);
        if (!any_grant && req[cand]) begin
          any_grant   = 1'b1;
          grant_idx   = cand;
          grant[cand] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/proc_mem_arb.sv
// proc_mem_arb
// One synchronous RAM shared by NPORTS requesters through a round-robin
// arbiter. Each accepted request (read or write) produces a one-cycle response
// pulse on the following cycle with the data on the shared rsp_data bus.
// Ports:
//   clk        in  1               rising-edge clock
//   reset      in  1               synchronous active-high reset
//   en         in  1               global enable; low blocks all grants
//   req_valid  in  NPORTS          per-port request valid
//   req_ready  out NPORTS          per-port grant (combinational)
//   req_write  in  NPORTS          per-port write(1)/read(0)
//   req_adr    in  NPORTS*ADR      per-port address, port i at [i*ADR +: ADR]
//   req_wdata  in  NPORTS*WIDTH    per-port write data, same slicing
//   rsp_valid  out NPORTS          one-hot response pulse
//   rsp_data   out WIDTH           response data, held between responses
module proc_mem_arb
  import proc_mem_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int RAM_ADR_BITS = 16,
  parameter int NPORTS       = 2,
  parameter int RD_MODE      = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [NPORTS-1:0]            req_valid,
  output logic [NPORTS-1:0]            req_ready,
  input  logic [NPORTS-1:0]            req_write,
  input  logic [NPORTS*RAM_ADR_BITS-1:0] req_adr,
  input  logic [NPORTS*WIDTH-1:0]      req_wdata,
  output logic [NPORTS-1:0]            rsp_valid,
  output logic [WIDTH-1:0]             rsp_data
);

  localparam int IW    = idx_width(NPORTS);
  localparam int DEPTH = 2 ** RAM_ADR_BITS;

  logic [IW-1:0]           ptr;
  logic [NPORTS-1:0]       grant;
  logic [IW-1:0]           grant_idx;
  logic                    any_grant;
  logic                    sel_write;
  logic [RAM_ADR_BITS-1:0] sel_adr;
  logic [WIDTH-1:0]        sel_wdata;
  logic [WIDTH-1:0]        ram [DEPTH];

  // Reset is folded into the arbiter enable so nothing (in particular no
  // write) can be accepted while reset is held.
  rr_arbiter #(.NPORTS(NPORTS)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (en & ~reset),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready = grant;

  // Route the granted port's command onto the single RAM port.
  always_comb begin
    sel_write = 1'b0;
    sel_adr   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_write = req_write[i];
        sel_adr   = req_adr[i*RAM_ADR_BITS +: RAM_ADR_BITS];
        sel_wdata = req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (any_grant && sel_write) begin
      ram[sel_adr] <= sel_wdata;
    end
  end

  // Registered response path and priority pointer. The RAM read sees the
  // pre-edge contents, which gives read-first behaviour; write-first simply
  // forwards the incoming write data instead.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= grant;
      if (any_grant) begin
        ptr <= (grant_idx == IW'(NPORTS - 1)) ? '0 : grant_idx + 1'b1;
        if (sel_write && (RD_MODE == WR_FIRST)) begin
          rsp_data <= sel_wdata;
        end else begin
          rsp_data <= ram[sel_adr];
        end
      end
    end
  end

endmodule

// File: tb/tb_proc_mem_arb.sv
// tb_proc_mem_arb
// Drives two instances (read-first and write-first) with identical stimulus
// and compares them against a behavioural model of the arbiter and memory.
module tb_proc_mem_arb;

  localparam int NP = 2;
  localparam int W  = 16;
  localparam int AB = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b1;
  logic [NP-1:0]     req_valid = '0;
  logic [NP-1:0]     req_write = '0;
  logic [NP*AB-1:0]  req_adr = '0;
  logic [NP*W-1:0]   req_wdata = '0;
  logic [NP-1:0]     rdy0, rdy1, rv0, rv1;
  logic [W-1:0]      rd0, rd1;

  int tests_run = 0;
  int tests_failed = 0;

  // model state
  int           mptr = 0;
  logic [W-1:0] mem [int];
  logic [NP-1:0] m_rv = '0;
  logic [W-1:0] m_d0 = '0, m_d1 = '0;
  bit           m_k0 = 1'b1, m_k1 = 1'b1;

  // per-cycle expectations and observations
  int            grant;
  logic [NP-1:0] exp_ready, exp_rv, obs_rdy0, obs_rdy1, obs_rv0, obs_rv1;
  logic [W-1:0]  exp_d0, exp_d1, obs_d0, obs_d1;
  bit            exp_k0, exp_k1;

  proc_mem_arb #(.WIDTH(W), .RAM_ADR_BITS(AB), .NPORTS(NP), .RD_MODE(0)) dut_rf (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_ready(rdy0),
    .req_write(req_write), .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_data(rd0)
  );

  proc_mem_arb #(.WIDTH(W), .RAM_ADR_BITS(AB), .NPORTS(NP), .RD_MODE(1)) dut_wf (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_ready(rdy1),
    .req_write(req_write), .req_adr(req_adr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_data(rd1)
  );

  always #5 clk = ~clk;

  // Sample both DUTs shortly after the inputs settle, derive the expected
  // grant from the round-robin rule, advance the model across the coming
  // edge, and return at the next falling edge.
  task automatic tick();
    logic [AB-1:0] a;
    logic [W-1:0]  wd, old;
    bit            known;
    #2;
    exp_rv = m_rv; exp_d0 = m_d0; exp_d1 = m_d1; exp_k0 = m_k0; exp_k1 = m_k1;
    obs_rdy0 = rdy0; obs_rdy1 = rdy1; obs_rv0 = rv0; obs_rv1 = rv1;
    obs_d0 = rd0; obs_d1 = rd1;
    grant = -1;
    if (en && !reset) begin
      for (int k = 0; k < NP; k++) begin
        if (grant < 0 && req_valid[(mptr + k) % NP]) grant = (mptr + k) % NP;
      end
    end
    exp_ready = (grant >= 0) ? NP'(1 << grant) : '0;
    if (reset) begin
      mptr = 0; m_rv = '0; m_d0 = '0; m_d1 = '0; m_k0 = 1'b1; m_k1 = 1'b1;
    end else if (grant >= 0) begin
      a = req_adr[grant*AB +: AB];
      wd = req_wdata[grant*W +: W];
      known = mem.exists(int'(a));
      old = known ? mem[int'(a)] : '0;
      m_d0 = old; m_k0 = known;
      if (req_write[grant]) begin
        m_d1 = wd; m_k1 = 1'b1;
        mem[int'(a)] = wd;
      end else begin
        m_d1 = old; m_k1 = known;
      end
      m_rv = NP'(1 << grant);
      mptr = (grant + 1) % NP;
    end else begin
      m_rv = '0;
    end
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input bit v, input bit wr, input logic [AB-1:0] a,
                          input logic [W-1:0] d);
    req_valid[p] = v;
    req_write[p] = wr;
    req_adr[p*AB +: AB] = a;
    req_wdata[p*W +: W] = d;
  endtask

  task automatic test_reset();
    set_port(0, 1, 1, 16'h0030, 16'hAAAA);
    set_port(1, 1, 1, 16'h0031, 16'hBBBB);
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if ({obs_rdy1, obs_rdy0} !== '0) begin
        tests_failed++;
        $display("[TB] FAIL reset_ready: got %b expected 0000", {obs_rdy1, obs_rdy0});
      end
    end
    reset = 1'b0;
    req_valid = '0;
    tick();
    tests_run++;
    if ({obs_rv1, obs_rv0, obs_d1, obs_d0} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {obs_rv1, obs_rv0, obs_d1, obs_d0});
    end
  endtask

  task automatic test_write_read();
    set_port(0, 1, 1, 16'h0010, 16'h1234);
    tick();
    tests_run++;
    if (obs_rdy0 !== 2'b01 || obs_rdy1 !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL wr_ready: got %b/%b expected 01", obs_rdy0, obs_rdy1);
    end
    req_valid = '0;
    tick();
    tests_run++;
    if (obs_rv0 !== 2'b01 || obs_rv1 !== 2'b01 || obs_d1 !== 16'h1234) begin
      tests_failed++;
      $display("[TB] FAIL wr_rsp: got %b/%b %h expected 01/01 1234", obs_rv0, obs_rv1, obs_d1);
    end
    set_port(0, 1, 0, 16'h0010, 16'h0000);
    tick();
    req_valid = '0;
    tick();
    tests_run++;
    if (obs_rv0 !== 2'b01 || obs_d0 !== 16'h1234 || obs_d1 !== 16'h1234) begin
      tests_failed++;
      $display("[TB] FAIL rd_rsp: got %b %h/%h expected 01 1234", obs_rv0, obs_d0, obs_d1);
    end
  endtask

  task automatic test_alternate();
    logic [NP-1:0] want;
    // a lone port1 grant brings the pointer back to 0
    set_port(1, 1, 0, 16'h0010, 16'h0000);
    tick();
    set_port(0, 1, 0, 16'h0010, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      tick();
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      tests_run++;
      if (obs_rdy0 !== want || obs_rdy1 !== want || obs_rdy0 !== exp_ready) begin
        tests_failed++;
        $display("[TB] FAIL alternate[%0d]: got %b/%b expected %b", i, obs_rdy0, obs_rdy1, want);
      end
    end
    req_valid = '0;
    tick();
    tests_run++;
    if (obs_rv0 !== 2'b10 || obs_d0 !== 16'h1234) begin
      tests_failed++;
      $display("[TB] FAIL alternate_rsp: got %b %h expected 10 1234", obs_rv0, obs_d0);
    end
  endtask

  task automatic test_rd_mode();
    set_port(0, 1, 1, 16'h0005, 16'h00AA);
    tick();
    req_valid = '0;
    set_port(1, 1, 1, 16'h0005, 16'h0055);
    tick();
    req_valid = '0;
    tick();
    tests_run++;
    if (obs_rv0 !== 2'b10 || obs_rv1 !== 2'b10 || obs_d0 !== 16'h00AA || obs_d1 !== 16'h0055) begin
      tests_failed++;
      $display("[TB] FAIL rd_mode: got %b %h/%h expected 10 00aa/0055", obs_rv0, obs_d0, obs_d1);
    end
  endtask

  task automatic test_enable();
    bit seen = 1'b0;
    set_port(0, 1, 1, 16'h0020, 16'hBEEF);
    tick();
    req_valid = '0;
    tick();
    en = 1'b0;
    set_port(0, 1, 1, 16'h0021, 16'h1111);
    set_port(1, 1, 0, 16'h0020, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({obs_rdy1, obs_rdy0, obs_rv1, obs_rv0} !== '0) begin
        tests_failed++;
        $display("[TB] FAIL en_low[%0d]: got %b expected 0", i, {obs_rdy1, obs_rdy0, obs_rv1, obs_rv0});
      end
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (grant >= 0) req_valid[grant] = 1'b0;
      if (obs_rv0[1]) begin
        seen = 1'b1;
        tests_run++;
        if (obs_d0 !== 16'hBEEF || obs_d1 !== 16'hBEEF) begin
          tests_failed++;
          $display("[TB] FAIL en_readback: got %h/%h expected beef", obs_d0, obs_d1);
        end
      end
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL en_timeout: got no port1 response expected one");
    end
  endtask

  task automatic test_reset_inflight();
    set_port(0, 1, 0, 16'h0010, 16'h0000);
    tick();
    req_valid = '0;
    reset = 1'b1;
    set_port(1, 1, 1, 16'h0010, 16'hDEAD);
    tick();
    tests_run++;
    if (obs_rdy0 !== 2'b00 || obs_rdy1 !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL inreset_ready: got %b/%b expected 00", obs_rdy0, obs_rdy1);
    end
    reset = 1'b0;
    req_valid = '0;
    tick();
    tests_run++;
    if ({obs_rv1, obs_rv0, obs_d1, obs_d0} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL inflight_dropped: got %h expected 0", {obs_rv1, obs_rv0, obs_d1, obs_d0});
    end
    set_port(0, 1, 0, 16'h0010, 16'h0000);
    set_port(1, 1, 0, 16'h0010, 16'h0000);
    tick();
    tests_run++;
    if (obs_rdy0 !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL ptr_after_reset: got %b expected 01", obs_rdy0);
    end
    req_valid[0] = 1'b0;
    tick();
    req_valid = '0;
    tests_run++;
    if (obs_rv0 !== 2'b01 || obs_d0 !== 16'h1234) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_write: got %b %h expected 01 1234", obs_rv0, obs_d0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1, 1, AB'(i), 16'hC000 + W'(i));
      tick();
    end
    req_valid = '0;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_port(1, 1, 0, AB'(i), 16'h0000);
      else req_valid = '0;
      tick();
      if (i < 4) begin
        tests_run++;
        if (obs_rdy0 !== 2'b10) begin
          tests_failed++;
          $display("[TB] FAIL b2b_ready[%0d]: got %b expected 10", i, obs_rdy0);
        end
      end
      if (i >= 1 && i <= 4) begin
        tests_run++;
        if (obs_rv0 !== 2'b10 || obs_d0 !== 16'hC000 + W'(i - 1) || obs_d1 !== obs_d0) begin
          tests_failed++;
          $display("[TB] FAIL b2b_rsp[%0d]: got %b %h/%h expected 10 %h", i, obs_rv0, obs_d0,
                   obs_d1, 16'hC000 + W'(i - 1));
        end
      end
    end
  endtask

  task automatic test_random();
    int last_grant = -1;
    int waits [NP] = '{default: 0};
    for (int a = 0; a < 8; a++) begin
      set_port(0, 1, 1, AB'(a), W'($urandom));
      tick();
    end
    req_valid = '0;
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req_valid[p] || last_grant == p) begin
          set_port(p, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                   AB'($urandom_range(0, 7)), W'($urandom));
        end
      end
      en = ($urandom_range(0, 9) != 0);
      tick();
      last_grant = grant;
      tests_run++;
      if (obs_rdy0 !== exp_ready || obs_rdy1 !== exp_ready || obs_rv0 !== exp_rv
          || obs_rv1 !== exp_rv) begin
        tests_failed++;
        $display("[TB] FAIL rand_ctl[%0d]: got %b %b %b %b expected %b %b", c, obs_rdy0,
                 obs_rdy1, obs_rv0, obs_rv1, exp_ready, exp_rv);
      end
      if (exp_k0 && exp_k1) begin
        tests_run++;
        if (obs_d0 !== exp_d0 || obs_d1 !== exp_d1) begin
          tests_failed++;
          $display("[TB] FAIL rand_data[%0d]: got %h/%h expected %h/%h", c, obs_d0, obs_d1,
                   exp_d0, exp_d1);
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (obs_rdy0[p]) begin
          tests_run++;
          if (waits[p] >= NP) begin
            tests_failed++;
            $display("[TB] FAIL fairness[%0d]: got wait %0d expected < %0d", p, waits[p], NP);
          end
          waits[p] = 0;
        end else if (req_valid[p] && en) begin
          waits[p]++;
        end
      end
    end
    req_valid = '0;
    en = 1'b1;
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_alternate();
    test_rd_mode();
    test_enable();
    test_reset_inflight();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
